// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the Viterbi decoder core: it buffers one frame of
// rate-1/2 symbols, clears the core's trellis, bursts the frame into the
// core on back-to-back cycles, and re-times the info-bit decisions into a
// framed output stream. Tail-bit decisions are discarded.
module viterbi_frame_ctrl #(
  parameter int FRAME_LEN = 16,
  parameter int TAIL_LEN  = 2,
  parameter int DEC_LAT   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] in_symbol,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] dec_symbol,
  output logic       dec_reset,
  input  logic       dec_bit,
  output logic       out_bit,
  output logic       out_valid,
  output logic       out_last,
  output logic       busy
);

  localparam int N  = FRAME_LEN + TAIL_LEN;
  localparam int TW = $clog2(N + DEC_LAT + 1);
  localparam int CW = $clog2(N + 1);

  localparam logic [TW-1:0] T_FEED_END  = TW'(N - 1);
  localparam logic [TW-1:0] T_DRAIN_END = TW'(N + DEC_LAT - 1);
  localparam logic [TW-1:0] T_CAP_LO    = TW'(DEC_LAT);
  localparam logic [TW-1:0] T_CAP_HI    = TW'(FRAME_LEN + DEC_LAT);
  localparam logic [TW-1:0] T_LAST      = TW'(FRAME_LEN + DEC_LAT - 1);
  localparam logic [CW-1:0] W_LAST      = CW'(N - 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_CLEAR,
    S_FEED,
    S_DRAIN
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_buf [N];
  logic [CW-1:0] r_wcnt;
  logic [CW-1:0] r_rcnt;
  logic [TW-1:0] r_tcnt;
  logic [1:0]    r_dec_symbol;
  logic          r_out_bit;
  logic          r_out_valid;
  logic          r_out_last;
  logic          w_accept;
  logic          w_capture;

  assign in_ready   = (r_state == S_FILL) && !reset;
  assign busy       = (r_state != S_FILL) && !reset;
  assign dec_reset  = reset || (r_state == S_CLEAR);
  assign dec_symbol = r_dec_symbol;
  assign out_bit    = r_out_bit;
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;

  assign w_accept  = in_valid && in_ready;
  // Info-bit decisions arrive DEC_LAT cycles after their symbol; tail ones are dropped.
  assign w_capture = ((r_state == S_FEED) || (r_state == S_DRAIN)) &&
                     (r_tcnt >= T_CAP_LO) && (r_tcnt < T_CAP_HI);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FILL;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:  if (w_accept && (r_wcnt == W_LAST)) w_state_nxt = S_CLEAR;
      S_CLEAR: w_state_nxt = S_FEED;
      S_FEED:  if (r_tcnt == T_FEED_END) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_tcnt == T_DRAIN_END) w_state_nxt = S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
  end

  // Frame buffer write port.
  always_ff @(posedge clk) begin
    if (w_accept) r_buf[r_wcnt] <= in_symbol;
  end

  // Counters, core symbol register and output re-timing.
  // dec_symbol is loaded one cycle ahead (r_rcnt = r_tcnt + 1) so that the
  // FEED cycle with tcnt=k presents buf[k] straight from a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wcnt       <= '0;
      r_rcnt       <= '0;
      r_tcnt       <= '0;
      r_dec_symbol <= '0;
      r_out_bit    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
    end else begin
      r_out_valid <= w_capture;
      r_out_last  <= w_capture && (r_tcnt == T_LAST);
      if (w_capture) r_out_bit <= dec_bit;
      case (r_state)
        S_FILL: begin
          r_dec_symbol <= '0;
          if (w_accept) r_wcnt <= r_wcnt + 1'b1;
        end
        S_CLEAR: begin
          r_dec_symbol <= r_buf[0];
          r_rcnt       <= CW'(1);
          r_tcnt       <= '0;
        end
        S_FEED: begin
          r_tcnt <= r_tcnt + 1'b1;
          r_rcnt <= r_rcnt + 1'b1;
          if (r_tcnt == T_FEED_END) r_dec_symbol <= '0;
          else                      r_dec_symbol <= r_buf[r_rcnt];
        end
        S_DRAIN: begin
          r_dec_symbol <= '0;
          if (r_tcnt == T_DRAIN_END) begin
            r_tcnt <= '0;
            r_wcnt <= '0;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        default: r_dec_symbol <= '0;
      endcase
    end
  end

endmodule
